// File: rtl/alu_sequencer.sv
// alu_sequencer
//
// Sequences one operation at a time through an external 4-bit combinational
// ALU. A request is accepted on a valid/ready handshake, its operands and
// opcode are driven onto the ALU for SETTLE cycles, and then the ALU outputs
// are captured and offered on a response valid/ready channel.
//
// State table
//   state      | meaning
//   ST_IDLE    | waiting for a request; req_ready high (outside reset)
//   ST_SETTLE  | operands held on the ALU, settle_cnt counting down
//   ST_RESP    | captured result presented, waiting for rsp_ready
//
// Ports
//   clk, rst_n                      clock, async active-low reset
//   req_valid/req_ready             request handshake
//   req_a, req_b, req_op            request operands and opcode
//   alu_a, alu_b, alu_op            registered drive to the ALU
//   alu_result/overflow/zero        ALU outputs
//   rsp_valid/rsp_ready             response handshake
//   rsp_result/overflow/zero/op     captured response
//   busy                            high whenever not idle
//   op_count                        completed responses, modulo 256
module alu_sequencer #(
    parameter int WIDTH  = 4,
    parameter int SETTLE = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [WIDTH-1:0] req_a,
    input  logic [WIDTH-1:0] req_b,
    input  logic [1:0]       req_op,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [1:0]       alu_op,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_overflow,
    input  logic             alu_zero,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_result,
    output logic             rsp_overflow,
    output logic             rsp_zero,
    output logic [1:0]       rsp_op,
    output logic             busy,
    output logic [7:0]       op_count
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE);

    state_t     state;
    state_t     state_nxt;
    logic [3:0] settle_cnt;
    logic       accept;
    logic       capture;
    logic       rsp_done;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        capture   = 1'b0;
        rsp_done  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (req_valid) begin
                    accept    = 1'b1;
                    state_nxt = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (settle_cnt == 4'd1) begin
                    capture   = 1'b1;
                    state_nxt = ST_RESP;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    rsp_done  = 1'b1;
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Operands, response registers and the settle timer. alu_* and rsp_*
    // deliberately keep their last values after the transaction completes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            settle_cnt   <= 4'd0;
            alu_a        <= '0;
            alu_b        <= '0;
            alu_op       <= 2'd0;
            rsp_valid    <= 1'b0;
            rsp_result   <= '0;
            rsp_overflow <= 1'b0;
            rsp_zero     <= 1'b0;
            rsp_op       <= 2'd0;
            op_count     <= 8'd0;
        end else begin
            if (accept) begin
                alu_a      <= req_a;
                alu_b      <= req_b;
                alu_op     <= req_op;
                settle_cnt <= SETTLE_LOAD;
            end else if (state == ST_SETTLE && settle_cnt != 4'd0) begin
                settle_cnt <= settle_cnt - 4'd1;
            end
            if (capture) begin
                rsp_valid    <= 1'b1;
                rsp_result   <= alu_result;
                rsp_overflow <= alu_overflow;
                rsp_zero     <= alu_zero;
                rsp_op       <= alu_op;
            end else if (rsp_done) begin
                rsp_valid <= 1'b0;
                op_count  <= op_count + 8'd1;
            end
        end
    end

    // Gated by rst_n so the requester never sees ready while held in reset.
    assign req_ready = (state == ST_IDLE) && rst_n;
    assign busy      = (state != ST_IDLE);

endmodule
